// File: rtl/flit_uart_rx.sv
// rtl/flit_uart_rx.sv - UART receiver assembling 16-byte checksummed flits
//
// Purpose: samples the inter-node serial link, assembles FLIT_BYTES bytes
// (byte 0 first, ending up in bits [127:120]) into a 128-bit flit, checks
// the trailing 16-bit checksum and presents good flits on a valid/ready port.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rxd_i          UART serial input, idle high, asynchronous to clk
//   flit_o         received flit, byte 0 = bits [127:120]
//   flit_valid_o   flit_o holds an accepted flit
//   flit_ready_i   consumer takes the flit when valid & ready
//   err_framing_o  pulse: stop bit sampled low
//   err_checksum_o pulse: checksum mismatch, flit dropped
//   err_overflow_o pulse: good flit arrived while output still occupied
//   err_timeout_o  pulse: partial flit abandoned after inter-byte gap
//   busy_o         bit FSM not idle or partial flit in progress
module flit_uart_rx #(
    parameter int CLK_DIV      = 868,
    parameter int FLIT_BYTES   = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rxd_i,
    output logic [127:0] flit_o,
    output logic         flit_valid_o,
    input  logic         flit_ready_i,
    output logic         err_framing_o,
    output logic         err_checksum_o,
    output logic         err_overflow_o,
    output logic         err_timeout_o,
    output logic         busy_o
);

    localparam int CNT_W     = $clog2(CLK_DIV) + 1;
    localparam int BCNT_W    = $clog2(FLIT_BYTES) + 1;
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLK_DIV;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(FLIT_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Line synchronizer; rx_prev_q gives the edge detector its history.
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic fall;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        byte_sh_q, byte_sh_d;
    logic              byte_done;
    logic              frame_err;

    logic [BCNT_W-1:0] byte_cnt_q;
    logic [127:0]      flit_sh_q;
    logic              eval_q;

    logic [TMO_W-1:0]  tmo_q;
    logic              tmo_counting;
    logic              tmo_hit;

    logic [15:0]       csum;
    logic              csum_ok;
    logic              handshake;

    logic [127:0]      flit_q;
    logic              flit_valid_q;
    logic              err_framing_q;
    logic              err_checksum_q;
    logic              err_overflow_q;
    logic              err_timeout_q;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // A line held low after a framing error produces no edge until it
    // has gone high again.
    assign fall = rx_prev_q & ~rx_sync_q;

    // ------------------------------------------------------------------
    // Bit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST && bit_idx_q == 3'd7) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit FSM: outputs (bit timer, data shifter, byte/framing strobes)
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        byte_sh_d = byte_sh_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            S_START: begin
                cnt_d = (cnt_q == HALF_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    byte_sh_d = {rx_sync_q, byte_sh_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    byte_done = rx_sync_q;
                    frame_err = ~rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            byte_sh_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_sh_q <= byte_sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout: only runs while a partial flit sits idle
    // ------------------------------------------------------------------
    assign tmo_counting = (state_q == S_IDLE) && (byte_cnt_q != '0) && !fall;
    assign tmo_hit      = tmo_counting && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (tmo_counting && !tmo_hit) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end else begin
            tmo_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Byte assembly; independent of the output register so reception
    // keeps going while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            flit_sh_q  <= '0;
            eval_q     <= 1'b0;
        end else begin
            eval_q <= 1'b0;
            if (frame_err || tmo_hit) begin
                byte_cnt_q <= '0;
                flit_sh_q  <= '0;
            end else if (byte_done) begin
                flit_sh_q <= {flit_sh_q[119:0], byte_sh_q};
                if (byte_cnt_q == BYTE_LAST) begin
                    byte_cnt_q <= '0;
                    eval_q     <= 1'b1;
                end else begin
                    byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checksum: 16-bit sum of the seven leading words, carries dropped
    // ------------------------------------------------------------------
    always_comb begin
        csum = '0;
        for (int i = 1; i < 8; i++) begin
            csum = csum + flit_sh_q[i*16 +: 16];
        end
    end

    assign csum_ok   = (csum == flit_sh_q[15:0]);
    assign handshake = flit_valid_q & flit_ready_i;

    // ------------------------------------------------------------------
    // Output register, handshake and error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_q         <= '0;
            flit_valid_q   <= 1'b0;
            err_framing_q  <= 1'b0;
            err_checksum_q <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            err_framing_q  <= frame_err;
            err_timeout_q  <= tmo_hit;
            err_checksum_q <= eval_q && !csum_ok;
            err_overflow_q <= eval_q && csum_ok && flit_valid_q && !handshake;

            // A slot freed by this cycle's handshake can take the new flit.
            if (eval_q && csum_ok && (!flit_valid_q || handshake)) begin
                flit_q       <= flit_sh_q;
                flit_valid_q <= 1'b1;
            end else if (handshake) begin
                flit_valid_q <= 1'b0;
            end
        end
    end

    assign flit_o         = flit_q;
    assign flit_valid_o   = flit_valid_q;
    assign err_framing_o  = err_framing_q;
    assign err_checksum_o = err_checksum_q;
    assign err_overflow_o = err_overflow_q;
    assign err_timeout_o  = err_timeout_q;
    assign busy_o         = (state_q != S_IDLE) || (byte_cnt_q != '0);

endmodule

// File: tb/tb_flit_uart_rx.sv
// tb/tb_flit_uart_rx.sv - directed self-checking bench for flit_uart_rx
module tb_flit_uart_rx;

    localparam int DIV = 16;

    logic         clk;
    logic         rst_n;
    logic         rxd;
    logic [127:0] flit;
    logic         flit_valid;
    logic         flit_ready;
    logic         err_framing;
    logic         err_checksum;
    logic         err_overflow;
    logic         err_timeout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Pulse/handshake monitor
    int           n_valid = 0;
    int           n_hs    = 0;
    int           n_fr    = 0;
    int           n_cs    = 0;
    int           n_ov    = 0;
    int           n_to    = 0;
    int           n_multi = 0;
    logic [127:0] last_flit = '0;

    // Hand-computed flits: words summed mod 2^16 into the last word.
    // A: 1005+072A+0001+0203+0405+0607+0809 = 2B48
    // B: 2021+2223+2425+2627+2829+2A2B+2C2D = 1_0B11 -> 0B11
    localparam logic [127:0] FLIT_A = 128'h1005_072A_0001_0203_0405_0607_0809_2B48;
    localparam logic [127:0] FLIT_B = 128'h2021_2223_2425_2627_2829_2A2B_2C2D_0B11;
    localparam logic [127:0] FLIT_A_BAD = 128'h1005_072A_0001_0203_0405_0607_0809_2B49;

    flit_uart_rx #(
        .CLK_DIV      (DIV),
        .FLIT_BYTES   (16),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rxd_i          (rxd),
        .flit_o         (flit),
        .flit_valid_o   (flit_valid),
        .flit_ready_i   (flit_ready),
        .err_framing_o  (err_framing),
        .err_checksum_o (err_checksum),
        .err_overflow_o (err_overflow),
        .err_timeout_o  (err_timeout),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (flit_valid) n_valid++;
        if (flit_valid && flit_ready) begin
            n_hs++;
            last_flit = flit;
        end
        if (err_framing)  n_fr++;
        if (err_checksum) n_cs++;
        if (err_overflow) n_ov++;
        if (err_timeout)  n_to++;
        if ((int'(err_framing) + int'(err_checksum) + int'(err_overflow) + int'(err_timeout)) > 1)
            n_multi++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge, clear of the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop_bit;
        tick(DIV);
        rxd = 1'b1;
    endtask

    task automatic send_flit(input logic [127:0] f);
        for (int i = 0; i < 16; i++) begin
            send_byte(f[127-8*i -: 8], 1'b1);
        end
    endtask

    initial begin
        int hs0;
        int cs0;
        rst_n      = 1'b0;
        rxd        = 1'b1;
        flit_ready = 1'b1;
        tick(3);

        // Reset state
        chk("rst_valid", 128'(flit_valid), 128'd0);
        chk("rst_flit", flit, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_errs", 128'({err_framing, err_checksum, err_overflow, err_timeout}), 128'd0);
        rst_n = 1'b1;
        tick(3);

        // Single good flit, consumer ready
        send_flit(FLIT_A);
        tick(4);
        chk("good_hs", 128'(n_hs), 128'd1);
        chk("good_valid_cycles", 128'(n_valid), 128'd1);
        chk("good_flit", last_flit, FLIT_A);
        chk("good_no_err", 128'(n_fr + n_cs + n_ov + n_to), 128'd0);
        chk("good_busy", 128'(busy), 128'd0);

        // Checksum error, then a good flit with a carry out of the sum
        send_flit(FLIT_A_BAD);
        tick(4);
        chk("cs_pulse", 128'(n_cs), 128'd1);
        chk("cs_no_valid", 128'(n_valid), 128'd1);
        send_flit(FLIT_B);
        tick(4);
        chk("cs_next_hs", 128'(n_hs), 128'd2);
        chk("cs_next_flit", last_flit, FLIT_B);

        // Backpressure and overflow
        flit_ready = 1'b0;
        send_flit(FLIT_A);
        tick(4);
        chk("bp_valid", 128'(flit_valid), 128'd1);
        chk("bp_flit", flit, FLIT_A);
        send_flit(FLIT_B);
        tick(4);
        chk("ov_pulse", 128'(n_ov), 128'd1);
        chk("ov_flit_held", flit, FLIT_A);
        chk("ov_valid_held", 128'(flit_valid), 128'd1);
        chk("ov_no_cs", 128'(n_cs), 128'd1);
        flit_ready = 1'b1;
        tick(1);
        chk("ov_drain_valid", 128'(flit_valid), 128'd0);
        chk("ov_drain_hs", 128'(n_hs), 128'd3);
        chk("ov_drain_flit", last_flit, FLIT_A);

        // Framing error on the stop bit of byte 5
        for (int i = 0; i < 4; i++) begin
            send_byte(FLIT_A[127-8*i -: 8], 1'b1);
        end
        send_byte(FLIT_A[95:88], 1'b0);
        tick(20);
        chk("fr_pulse", 128'(n_fr), 128'd1);
        chk("fr_busy", 128'(busy), 128'd0);
        send_flit(FLIT_B);
        tick(4);
        chk("fr_next_hs", 128'(n_hs), 128'd4);
        chk("fr_next_flit", last_flit, FLIT_B);

        // Timeout: 7 bytes then idle; pulse lands 64 cycles after the
        // last stop-bit sample, i.e. 59 ticks after the stop bit ends.
        for (int i = 0; i < 7; i++) begin
            send_byte(FLIT_A[127-8*i -: 8], 1'b1);
        end
        chk("to_busy_partial", 128'(busy), 128'd1);
        tick(58);
        chk("to_early", 128'(n_to), 128'd0);
        tick(1);
        chk("to_pulse", 128'(err_timeout), 128'd1);
        tick(1);
        chk("to_pulse_width", 128'(err_timeout), 128'd0);
        chk("to_count", 128'(n_to), 128'd1);
        chk("to_busy_cleared", 128'(busy), 128'd0);
        send_flit(FLIT_A);
        tick(4);
        chk("to_next_flit", last_flit, FLIT_A);
        chk("to_next_hs", 128'(n_hs), 128'd5);

        // Glitch on idle line
        hs0 = n_hs;
        cs0 = n_cs;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        chk("gl_busy", 128'(busy), 128'd0);
        send_flit(FLIT_B);
        tick(4);
        chk("gl_next_flit", last_flit, FLIT_B);
        chk("gl_next_hs", 128'(n_hs - hs0), 128'd1);
        chk("gl_no_cs", 128'(n_cs - cs0), 128'd0);

        // Reset mid-DATA with a pending output flit
        flit_ready = 1'b0;
        send_flit(FLIT_A);
        tick(4);
        chk("rm_pending", 128'(flit_valid), 128'd1);
        rxd = 1'b0;
        tick(DIV);
        rxd = 1'b1;
        tick(20);
        chk("rm_busy_data", 128'(busy), 128'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_valid", 128'(flit_valid), 128'd0);
        chk("rm_flit", flit, 128'd0);
        chk("rm_busy", 128'(busy), 128'd0);
        chk("rm_errs", 128'({err_framing, err_checksum, err_overflow, err_timeout}), 128'd0);
        tick(2);
        rst_n      = 1'b1;
        flit_ready = 1'b1;
        tick(5);
        hs0 = n_hs;
        send_flit(FLIT_B);
        tick(4);
        chk("rm_next_flit", last_flit, FLIT_B);
        chk("rm_next_hs", 128'(n_hs - hs0), 128'd1);

        chk("no_dual_err", 128'(n_multi), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flit_uart_rx.md
Name: flit_uart_rx

Overview:
- UART receive end of the inter-node flit link; the counterpart of the flit UART transmitter.
- Samples the serial line, assembles 16 bytes into one 128-bit flit_t, verifies the 16-bit checksum, and presents accepted flits on a valid/ready interface to the router/packet buffer.
- Framing, checksum, overflow and timeout errors are reported as single-cycle pulses; the noc error logic maps overflow onto RX_BUFFER_OVERFLOW.

Parameters:
- CLK_DIV, 868, clk cycles per UART bit (100 MHz / 115200); counter width is $clog2(CLK_DIV)+1, never truncated to 8 bits.
- FLIT_BYTES, 16, bytes per flit (FLIT_WIDTH/8); fixed for FLIT_WIDTH=128.
- TIMEOUT_BITS, 32, idle bit-periods allowed between bytes of a partially received flit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rxd_i  in  1  UART serial input; idle high; asynchronous to clk
- flit_o  out  128  received flit (flit_t); byte 0 = bits [127:120]
- flit_valid_o  out  1  flit_o holds an accepted flit
- flit_ready_i  in  1  consumer accepts flit when valid & ready
- err_framing_o  out  1  pulse: stop bit sampled low
- err_checksum_o  out  1  pulse: checksum mismatch, flit dropped
- err_overflow_o  out  1  pulse: good flit completed while output still occupied, new flit dropped
- err_timeout_o  out  1  pulse: partial flit abandoned after inter-byte gap
- busy_o  out  1  high while bit FSM is not IDLE or the byte count is nonzero

Behaviour:
- Reset: all outputs 0, flit_o = 0, FSM IDLE, byte count 0, timeout counter 0. rxd_i passes through a 2-flop synchronizer reset to 1.
- Bit FSM:
  - IDLE -> START on synchronized falling edge.
  - START: wait CLK_DIV/2 cycles, then resample. If high, treat as a glitch and return to IDLE. If low -> DATA.
  - DATA: sample every CLK_DIV cycles, 8 bits LSB first -> STOP.
  - STOP: sample after CLK_DIV cycles. If 1, the byte is complete -> IDLE. If 0, pulse err_framing_o, discard the partial flit, clear the byte count, and go to IDLE; a new start is only detected after rxd returns high.
- Byte assembly:
  - Each completed byte shifts into a 128-bit shift register MSB first and increments the byte count.
  - On the 16th byte, the byte count returns to 0 and the checksum is evaluated in the following cycle, giving one-cycle latency.
- Checksum:
  - calc = sum of the seven 16-bit words flit[127:112], flit[111:96], ..., flit[31:16], modulo 2^16 (carries discarded).
  - Accept when calc == flit[15:0].
- Acceptance and handshake:
  - Accepted flit with flit_valid_o=0: load flit_o and set flit_valid_o the cycle after evaluation.
  - Accepted flit with flit_valid_o=1 and no handshake in that same cycle: drop the flit and pulse err_overflow_o.
  - Handshake in the same cycle as acceptance: the new flit loads and valid stays 1.
  - Mismatch: pulse err_checksum_o; output is untouched.
  - Checksum errors take priority over overflow; only one error pulse is issued per flit.
- flit_valid_o stays high and flit_o stays stable until the cycle where flit_valid_o & flit_ready_i; valid clears the next cycle unless a new flit loads in that same cycle.
- Reception continues while the output is stalled; the shift register is independent of the output register.
- Timeout:
  - While the byte count is nonzero and the FSM is IDLE, count clk cycles. A start edge resets the count.
  - At TIMEOUT_BITS*CLK_DIV, pulse err_timeout_o, clear the byte count, and discard the partial flit.
  - No timeout is counted while the byte count is 0.
- Reset mid-byte or mid-flit: everything is cleared immediately. A pending output flit is lost and flit_valid_o drops asynchronously.
- Error pulses are exactly one clk wide. Two error types never pulse in the same cycle.

Test Plan:
- Single good flit: CLK_DIV=16, send header 0x1_0_05_07_2A00, payload bytes 0x01..0x09, correct checksum; ready=1 -> flit_valid_o for exactly 1 cycle, flit_o equals the sent 128 bits, no error pulses.
- Checksum error: same flit with checksum XOR 0x0001 -> err_checksum_o one pulse, flit_valid_o stays 0, next good flit is received normally.
- Backpressure/overflow: ready=0, send two good flits A then B -> A held stable on flit_o, err_overflow_o pulses once when B completes; raise ready -> A consumed, valid drops.
- Framing: force the stop bit of byte 5 low -> err_framing_o pulses; the following full 16-byte good flit is accepted intact, not shifted by the 5 lost bytes.
- Timeout: TIMEOUT_BITS=4, send 7 bytes, then hold idle for 64 cycles -> err_timeout_o pulses at cycle 64 after the last stop-bit sample; the next 16 bytes form a correct flit.
- Glitch/reset: 3-cycle low glitch on idle rxd -> no byte counted; assert rst_n mid-DATA -> all outputs 0 and busy_o=0; after release the next flit is received correctly.
